// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART_TX serializer among N_REQ producers
//
// Purpose:
//   Grants one requester at a time, loads its byte into UART_TX with a one-cycle
//   write pulse, then holds until UART_TX reports the byte has left the line.
//   Grants rotate starting after the last owner, so every requester is served.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a BUSY watchdog aborts a byte that never reports tx_done and
//   pulses o_err. When undefined, BUSY waits indefinitely and o_err is tied 0.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_req        per-requester byte-pending flags
//   i_req_data   packed bytes, slice i = i_req_data[i*DATA_W +: DATA_W]
//   o_ack        1-cycle pulse to the winner: its byte has been captured
//   o_done       1-cycle pulse to the owner: its byte is fully sent
//   o_busy       high from grant until return to IDLE
//   o_owner      index of the current/last granted requester
//   o_tx_wr_en   1-cycle load strobe to UART_TX
//   o_tx_data    byte to UART_TX, held stable through BUSY
//   i_tx_done    TX_Done from UART_TX
//   o_err        1-cycle pulse on watchdog abort

module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 8192,
  localparam int IDW           = $clog2(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]          o_ack,
  output logic [N_REQ-1:0]          o_done,
  output logic                      o_busy,
  output logic [IDW-1:0]            o_owner,
  output logic                      o_tx_wr_en,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_done,
  output logic                      o_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [N_REQ-1:0]    r_ack, w_ack_nxt;
  logic [N_REQ-1:0]    r_done, w_done_nxt;
  logic                r_busy, w_busy_nxt;
  logic [IDW-1:0]      r_owner, w_owner_nxt;
  logic                r_tx_wr_en, w_tx_wr_en_nxt;
  logic [DATA_W-1:0]   r_tx_data, w_tx_data_nxt;

  logic [DATA_W-1:0]   w_slice [N_REQ];
  logic                w_found;
  logic [IDW-1:0]      w_win;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic                r_err, w_err_nxt;
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign w_slice[g] = i_req_data[g*DATA_W +: DATA_W];
  end

  // Search starts one past the last owner and wraps, which gives the rotation.
  always_comb begin
    int s;
    w_found = 1'b0;
    w_win   = r_owner;
    for (int k = 1; k <= N_REQ; k++) begin
      s = int'(r_owner) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (!w_found && i_req[IDW'(s)]) begin
        w_found = 1'b1;
        w_win   = IDW'(s);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ack_nxt      = '0;
    w_done_nxt     = '0;
    w_tx_wr_en_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_owner_nxt    = r_owner;
    w_tx_data_nxt  = r_tx_data;
`ifdef UART_ARB_TIMEOUT_EN
    w_err_nxt      = 1'b0;
    w_cnt_nxt      = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_tx_data_nxt      = w_slice[w_win];
          w_tx_wr_en_nxt     = 1'b1;
          w_ack_nxt[w_win]   = 1'b1;
          w_owner_nxt        = w_win;
          w_busy_nxt         = 1'b1;
          w_state_nxt        = S_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          w_cnt_nxt          = '0;
`endif
        end
      end
      S_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
        w_cnt_nxt = r_cnt + 1'b1;
`endif
        // A tx_done seen while the load strobe is still out belongs to an
        // earlier frame, so it must not end this one.
        if (r_tx_wr_en) begin
          w_state_nxt = S_BUSY;
        end else if (i_tx_done) begin
          w_done_nxt[r_owner] = 1'b1;
          w_busy_nxt          = 1'b0;
          w_state_nxt         = S_IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_ack      <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_owner    <= IDW'(N_REQ - 1);
      r_tx_wr_en <= 1'b0;
      r_tx_data  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ack      <= w_ack_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_owner    <= w_owner_nxt;
      r_tx_wr_en <= w_tx_wr_en_nxt;
      r_tx_data  <= w_tx_data_nxt;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  assign o_ack      = r_ack;
  assign o_done     = r_done;
  assign o_busy     = r_busy;
  assign o_owner    = r_owner;
  assign o_tx_wr_en = r_tx_wr_en;
  assign o_tx_data  = r_tx_data;
`ifdef UART_ARB_TIMEOUT_EN
  assign o_err      = r_err;
`else
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     owner;
  logic           tx_wr_en;
  logic [W-1:0]   tx_data;
  logic           tx_done;
  logic           err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N),
    .DATA_W(W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req(req),
    .i_req_data(req_data),
    .o_ack(ack),
    .o_done(done),
    .o_busy(busy),
    .o_owner(owner),
    .o_tx_wr_en(tx_wr_en),
    .o_tx_data(tx_data),
    .i_tx_done(tx_done),
    .o_err(err)
  );

  typedef struct {
    int         own;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input int own);
    exp_t e;
    e.own  = own;
    e.data = req_data[own*W +: W];
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string tag, output int cycles);
    exp_t e;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tx_wr_en && cycles < 50);
    chk({tag, "_grant"}, 32'(tx_wr_en), 32'd1);
    if (tx_wr_en && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_owner"}, 32'(owner), 32'(e.own));
      chk({tag, "_data"}, 32'(tx_data), 32'(e.data));
      chk({tag, "_ack"}, 32'(ack), 32'(1 << e.own));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic finish_byte(input string tag, input int own);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'(1 << own));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    int order [5] = '{0, 1, 2, 3, 0};

    // T1: reset with all requesting
    rst      = 1'b0;
    tx_done  = 1'b0;
    req      = 4'hF;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(tx_wr_en), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_owner", 32'(owner), 32'd3);
    rst = 1'b1;
    expect_grant(0);
    wait_grant("t1", cyc);
    chk("t1_latency", 32'(cyc), 32'd1);
    req = 4'h0;
    finish_byte("t1", 0);

    // T2 + T4: single requester, stale tx_done during the load cycle
    req_data = {8'h00, 8'hA9, 8'h00, 8'h00};
    req      = 4'b0100;
    expect_grant(2);
    wait_grant("t2", cyc);
    req     = 4'h0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("t4_stale_done", 32'(done), 32'd0);
    chk("t4_stale_busy", 32'(busy), 32'd1);
    chk("t4_stale_wr", 32'(tx_wr_en), 32'd0);
    chk("t4_stale_ack", 32'(ack), 32'd0);
    finish_byte("t2", 2);

    // T4: tx_done while idle
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("t4_idle_done", 32'(done), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_idle_wr", 32'(tx_wr_en), 32'd0);
    chk("t4_idle_owner", 32'(owner), 32'd2);

    // T5: reset two cycles after a grant
    req_data = {8'h00, 8'h00, 8'h55, 8'h00};
    req      = 4'b0010;
    expect_grant(1);
    wait_grant("t5", cyc);
    req = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_owner", 32'(owner), 32'd3);
    chk("t5_data", 32'(tx_data), 32'd0);

    // T3: fairness with every requester holding req, back-to-back grants
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req      = 4'hF;
    for (int i = 0; i < 5; i++) expect_grant(order[i]);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_grant($sformatf("t3_%0d", i), cyc);
      chk($sformatf("t3_latency_%0d", i), 32'(cyc), 32'd1);
      if (i == 4) req = 4'h0;
      finish_byte($sformatf("t3_%0d", i), order[i]);
    end
    @(negedge clk);
    chk("t3_quiet", 32'(tx_wr_en), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
    // T6: watchdog abort, pending requester served next
    req_data = {8'h00, 8'h00, 8'h00, 8'hC3};
    req      = 4'b0001;
    expect_grant(0);
    wait_grant("t6a", cyc);
    req_data = {8'h00, 8'h00, 8'h5A, 8'h00};
    req      = 4'b0010;
    expect_grant(1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 40);
    chk("t6_err_cycle", 32'(n), 32'd16);
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    wait_grant("t6b", cyc);
    chk("t6_latency", 32'(cyc), 32'd1);
    req = 4'h0;
    finish_byte("t6", 1);
`else
    n = 0;
`endif

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
